// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/clk_sync_edge_det.sv
// Synchronizes an asynchronous level into sys_clk and flags its edges.
// SYNC_STAGES must be at least 2.
module clk_sync_edge_det
  import clk_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_d;

  // Synchronizer chain plus one delayed copy of the last stage for edge detection.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
      sync_d  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
      sync_d  <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign level = sync_ff[SYNC_STAGES-1];
  assign rise  = level & ~sync_d;
  assign fall  = ~level & sync_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous clock in sys_clk cycles,
// flags a lost clock and checks the period against an expected value.
// Optional macro CLK_PERIOD_METER_CONTINUOUS_EN: back-to-back measurements,
// one done pulse per period, until the clock is lost.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000,
  parameter int TOL         = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             start,
  input  logic [CNT_W-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             in_range,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W:0]   TOL_W = (CNT_W+1)'(TOL);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] high_cap, high_cap_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             in_range_nxt, lost_nxt, tmo;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             rise, fall, lvl_unused;

  clk_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .async_in (clk_in),
    .level    (lvl_unused),
    .rise     (rise),
    .fall     (fall)
  );

  // Counter saturates at the timeout value so it can never wrap.
  assign cnt_inc = (cnt == TMO) ? cnt : cnt + CNT_W'(1);

  // Absolute period error, one bit wider so the subtraction cannot wrap.
  assign diff   = ({1'b0, cnt} >= {1'b0, expected}) ? {1'b0, cnt} - {1'b0, expected}
                                                    : {1'b0, expected} - {1'b0, cnt};
  assign in_tol = (diff <= TOL_W);

  // State register.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, counter/capture updates and status outputs.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    high_cap_nxt  = high_cap;
    period_nxt    = period;
    high_time_nxt = high_time;
    in_range_nxt  = in_range;
    lost_nxt      = lost;
    tmo           = 1'b0;
    busy          = (state != IDLE);
    done          = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          cnt_nxt   = '0;
          lost_nxt  = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          state_nxt    = MEAS;
          cnt_nxt      = CNT_W'(1);
          high_cap_nxt = '0;
        end else if (cnt == TMO) begin
          tmo = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      MEAS: begin
        // A rise wins over a simultaneous timeout.
        if (rise) begin
          state_nxt     = DONE;
          period_nxt    = cnt;
          high_time_nxt = high_cap;
          in_range_nxt  = in_tol;
          // The closing rise doubles as the opening rise of a following period.
          cnt_nxt       = CNT_W'(1);
          high_cap_nxt  = '0;
        end else if (cnt == TMO) begin
          tmo = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
          if (fall) high_cap_nxt = cnt;
        end
      end
      DONE: begin
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
        // Keep measuring the running period; a lost clock ends the run.
        state_nxt = lost ? IDLE : MEAS;
        cnt_nxt   = cnt_inc;
        if (fall) high_cap_nxt = cnt;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo) begin
      state_nxt     = DONE;
      lost_nxt      = 1'b1;
      period_nxt    = '0;
      high_time_nxt = '0;
      in_range_nxt  = 1'b0;
    end
  end

  // Counter, high-time capture and result registers.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      high_cap  <= '0;
      period    <= '0;
      high_time <= '0;
      in_range  <= 1'b0;
      lost      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      high_cap  <= high_cap_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      in_range  <= in_range_nxt;
      lost      <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: table of clock shapes plus
// hand-written timeout, reset, busy-start and single-shot/continuous sequences.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 600;
  localparam int TOL   = 1;

  logic             sys_clk = 1'b0;
  logic             reset   = 1'b0;
  logic             clk_in  = 1'b0;
  logic             start   = 1'b0;
  logic [CNT_W-1:0] expected = '0;
  logic             busy, done, in_range, lost;
  logic [CNT_W-1:0] period, high_time;

  int total = 0;
  int bad   = 0;
  int hi_len = 0, lo_len = 0, ph = 0;

  typedef struct {
    int               hi;
    int               lo;
    logic [CNT_W-1:0] exp_in;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hig;
    logic             inr;
  } vec_t;
  vec_t vecs[9];

  clk_period_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .TOL(TOL)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .clk_in    (clk_in),
    .start     (start),
    .expected  (expected),
    .busy      (busy),
    .done      (done),
    .period    (period),
    .high_time (high_time),
    .in_range  (in_range),
    .lost      (lost)
  );

  always #5 sys_clk = ~sys_clk;

  // Clock-under-test: hi_len cycles high, lo_len low, changes on negedge; hi_len=0 holds it low.
  initial forever begin
    @(negedge sys_clk);
    if (hi_len == 0) clk_in = 1'b0;
    else begin
      clk_in = (ph < hi_len);
      ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_clk(input int h, input int l);
    @(posedge sys_clk);
    hi_len = h;
    lo_len = l;
    ph     = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge sys_clk);
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Return to IDLE after a measurement; continuous runs need a reset to stop.
  task automatic finish_meas(input string name);
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
    reset = 1'b0;
    @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    chk({name, "_idle"}, busy, 0);
`else
    @(negedge sys_clk);
    chk({name, "_done_1cyc"}, done, 0);
    chk({name, "_busy_off"}, busy, 0);
`endif
  endtask

  initial begin
    int  n, ndone, k;
    bit  ok, seen;
    logic [CNT_W-1:0] p_seen, h_seen;

    vecs[0] = '{1,  1,  16'd2,  16'd2,  16'd1,  1'b1};
    vecs[1] = '{15, 15, 16'd30, 16'd30, 16'd15, 1'b1};
    vecs[2] = '{15, 15, 16'd33, 16'd30, 16'd15, 1'b0};
    vecs[3] = '{15, 15, 16'd31, 16'd30, 16'd15, 1'b1};
    vecs[4] = '{15, 15, 16'd29, 16'd30, 16'd15, 1'b1};
    vecs[5] = '{15, 15, 16'd28, 16'd30, 16'd15, 1'b0};
    vecs[6] = '{3,  5,  16'd8,  16'd8,  16'd3,  1'b1};
    vecs[7] = '{5,  3,  16'd0,  16'd8,  16'd5,  1'b0};
    vecs[8] = '{2,  1,  16'd4,  16'd3,  16'd2,  1'b1};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_inr", in_range, 0);
    chk("rst_lost", lost, 0);
    reset = 1'b1;
    @(negedge sys_clk);

    // Table of clock shapes and expected values
    for (int i = 0; i < 9; i++) begin
      set_clk(vecs[i].hi, vecs[i].lo);
      repeat (2 * (vecs[i].hi + vecs[i].lo) + 6) @(negedge sys_clk);
      expected = vecs[i].exp_in;
      pulse_start();
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done(3 * (vecs[i].hi + vecs[i].lo) + 10, n, ok);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      chk($sformatf("v%0d_period", i), period, vecs[i].per);
      chk($sformatf("v%0d_high", i), high_time, vecs[i].hig);
      chk($sformatf("v%0d_inr", i), in_range, vecs[i].inr);
      chk($sformatf("v%0d_lost", i), lost, 0);
      finish_meas($sformatf("v%0d", i));
    end

    // Timeout: clk_in held low, done exactly TMO+2 cycles after the start cycle
    set_clk(0, 0);
    repeat (6) @(negedge sys_clk);
    expected = 16'd10;
    pulse_start();
    chk("tmo_busy", busy, 1);
    n  = 1;
    ok = 1'b0;
    while (n < TMO + 20) begin
      @(negedge sys_clk);
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_done_seen", ok, 1);
    chk("tmo_latency", n, TMO + 2);
    chk("tmo_lost", lost, 1);
    chk("tmo_period", period, 0);
    chk("tmo_high", high_time, 0);
    chk("tmo_inr", in_range, 0);
    @(negedge sys_clk);
    chk("tmo_busy_off", busy, 0);
    chk("tmo_done_off", done, 0);

    // start pulses while busy are ignored; lost clears only on the accepted start
    set_clk(4, 4);
    repeat (30) @(negedge sys_clk);
    chk("lost_held_idle", lost, 1);
    expected = 16'd8;
    ndone = 0;
    seen  = 1'b0;
    k     = 0;
    p_seen = '0;
    h_seen = '0;
    for (int i = 0; i < 80 && k < 6; i++) begin
      start = (!seen && (i % 3 == 0));
      @(negedge sys_clk);
      if (i == 0) chk("lost_cleared", lost, 0);
      if (done) begin
        ndone++;
        if (!seen) begin
          p_seen = period;
          h_seen = high_time;
        end
        seen = 1'b1;
      end
      if (seen) k++;
    end
    start = 1'b0;
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_period", p_seen, 8);
    chk("busy_start_high", h_seen, 4);
`ifndef CLK_PERIOD_METER_CONTINUOUS_EN
    chk("busy_start_idle", busy, 0);
`else
    finish_meas("busy_start");
`endif

    // Reset mid-measurement on a divide-by-512 clock
    set_clk(0, 0);
    repeat (6) @(negedge sys_clk);
    expected = 16'd512;
    pulse_start();
    set_clk(256, 256);
    repeat (200) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_period", period, 0);
    chk("mrst_high", high_time, 0);
    chk("mrst_inr", in_range, 0);
    chk("mrst_lost", lost, 0);
    reset = 1'b1;
    ndone = 0;
    repeat (700) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    chk("mrst_no_done", ndone, 0);
    pulse_start();
    wait_done(1200, n, ok);
    chk("d512_done_seen", ok, 1);
    chk("d512_period", period, 512);
    chk("d512_high", high_time, 256);
    chk("d512_inr", in_range, 1);
    finish_meas("d512");

`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
    // Continuous: one start, a done every 8 cycles, then a lost clock ends the run
    set_clk(4, 4);
    repeat (20) @(negedge sys_clk);
    expected = 16'd8;
    pulse_start();
    wait_done(40, n, ok);
    chk("cont_first_done", ok, 1);
    for (int i = 0; i < 4; i++) begin
      wait_done(20, n, ok);
      chk($sformatf("cont%0d_spacing", i), n, 8);
      chk($sformatf("cont%0d_period", i), period, 8);
      chk($sformatf("cont%0d_high", i), high_time, 4);
      chk($sformatf("cont%0d_inr", i), in_range, 1);
    end
    set_clk(0, 0);
    wait_done(TMO + 40, n, ok);
    chk("cont_lost_done", ok, 1);
    chk("cont_lost", lost, 1);
    chk("cont_lost_period", period, 0);
    @(negedge sys_clk);
    chk("cont_idle", busy, 0);
`else
    // Single-shot: one done only, even with the clock still running
    set_clk(4, 4);
    repeat (20) @(negedge sys_clk);
    expected = 16'd8;
    pulse_start();
    wait_done(40, n, ok);
    chk("ss_done_seen", ok, 1);
    chk("ss_period", period, 8);
    ndone = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    chk("ss_no_more_done", ndone, 0);
    chk("ss_idle", busy, 0);
    chk("ss_result_held", high_time, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures a divided or external clock from its receiving side.
- Samples an asynchronous clock-under-test `clk_in` into the sys_clk domain and counts sys_clk cycles between two consecutive rising edges (period) and from the rising edge to the falling edge (high time).
- Flags a lost clock and checks the measured period against an expected value.
- Used as a self-check on the divided clocks and on any incoming bit/frame clocks.

Parameters:
- CNT_W, 16, width of the cycle counter and the period/high_time outputs.
- SYNC_STAGES, 2, number of synchronizer flops on clk_in (minimum 2).
- TIMEOUT_CYC, 20000, counter value at which the measured clock is declared lost (must be < 2**CNT_W).
- TOL, 1, allowed absolute period error in cycles for in_range.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_in  in  1  asynchronous clock under test
- start  in  1  one-cycle pulse; starts a measurement, sampled only in IDLE
- expected  in  CNT_W  expected period in sys_clk cycles
- busy  out  1  high in ARM, MEAS and DONE
- done  out  1  one-cycle pulse; result outputs are valid and stable from this cycle
- period  out  CNT_W  measured period
- high_time  out  CNT_W  measured high time
- in_range  out  1  |period - expected| <= TOL; compare computed at CNT_W+1 bits, no wrap
- lost  out  1  timeout occurred; held until the next accepted start

Behaviour:
- Reset state:
  - state = IDLE.
  - All outputs 0; counter 0; synchronizer flops 0.
  - Reset mid-operation aborts at once; no done pulse.
- Edge detection:
  - sync = last synchronizer stage; sync_d = sync delayed by 1 cycle.
  - rise = sync & ~sync_d; fall = ~sync & sync_d.
  - Minimum measurable period is 2 cycles.
- IDLE:
  - start=1 → ARM, cnt <= 0, lost <= 0.
  - Previous results are held.
- ARM:
  - cnt increments each cycle.
  - rise → MEAS, cnt <= 1, high_cap <= 0.
  - Otherwise, cnt == TIMEOUT_CYC → timeout.
- MEAS:
  - cnt increments, saturating at TIMEOUT_CYC.
  - fall → high_cap <= cnt.
  - rise → period <= cnt, high_time <= high_cap, in_range updated; go to DONE.
  - Otherwise, cnt == TIMEOUT_CYC → timeout.
- Timeout:
  - lost <= 1; period, high_time and in_range <= 0; go to DONE.
  - Rise and timeout in the same cycle: the rise wins.
- DONE:
  - done = 1 for exactly one cycle, then → IDLE.
- Timing:
  - For edges detected at cycles t0 and t1: period = t1 - t0, and done is high at cycle t1+1.
  - Timeout with start at cycle s: done is high at cycle s + TIMEOUT_CYC + 2.
- start while busy (ARM, MEAS or DONE) is ignored.
- expected is sampled in the capture cycle.

Optional Feature:
- Macro: CLK_PERIOD_METER_CONTINUOUS_EN.
- Defined:
  - The closing rise of a measurement is also the opening rise of the next one: on capture, cnt <= 1 and high_cap <= 0.
  - DONE → MEAS. Counting and fall capture continue during DONE.
  - The result registers update only at rise captures.
  - done pulses once per measured period, indefinitely.
  - A timeout still goes DONE → IDLE.
  - start is needed only to leave IDLE.
- Undefined: single-shot operation as above.

Decomposition:
- Package clk_period_meter_pkg:
  - state enum {IDLE, ARM, MEAS, DONE}, 2 bits.
  - Default CNT_W constant.
- Sub-module clk_sync_edge_det:
  - Parameter SYNC_STAGES.
  - Inputs: sys_clk, reset, async_in.
  - Outputs: level, rise, fall.

Test Plan:
1. clk_in toggling every sys_clk (divide-by-2); expected=2; start → done with period=2, high_time=1, in_range=1, lost=0.
2. Divide-by-30 clock (15 high / 15 low); expected=30 → period=30, high_time=15, in_range=1. Repeat with expected=33, TOL=1 → in_range=0.
3. clk_in held 0; TIMEOUT_CYC=100; start at cycle s → done at s+102, lost=1, period=0, high_time=0, busy falls the following cycle.
4. Divide-by-512 clock:
   - Reset pulsed mid-MEAS → all outputs 0 and no done pulse.
   - After reset release, start → period=512, high_time=256.
5. start pulses repeated during ARM and MEAS on a divide-by-8 clock → a single done with period=8, high_time=4. The lost flag from a prior timeout clears only on the accepted start.
6. With CLK_PERIOD_METER_CONTINUOUS_EN, divide-by-8 clock, one start → done every 8 cycles, each with period=8 and high_time=4. Stopping clk_in → lost=1, then IDLE.
